store_sequencer: RTL and testbench

Buffered store controller between the core's memory stage and the data-memory write port. It accepts byte, halfword and word store requests through a valid/ready handshake and queues them in a small FIFO. Each request is converted into one or two word-aligned, byte-masked memory writes, so stores that cross a word boundary are split across consecutive words. Writes are issued in strict request order.

---
 rtl/store_sequencer.sv | 149 ++++++++++++++
 tb/tb_store_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_sequencer.sv
// Buffered store controller: queues byte/half/word stores in a small FIFO and issues them
// as one or two word-aligned, byte-masked write beats in strict request order.
module store_sequencer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_wen,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_wmask,
  output logic        busy,
  output logic        split,
  output logic        err_size
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e state_q, state_d;

  logic [29:0]     waddr_q [DEPTH];
  logic [63:0]     data_q  [DEPTH];
  logic [7:0]      mask_q  [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q;

  logic        full, accept, push, pop, illegal;
  logic [3:0]  base_mask;
  logic [31:0] size_data;
  logic [7:0]  enq_mask;
  logic [63:0] enq_data;
  logic [29:0] head_waddr;
  logic [63:0] head_data;
  logic [7:0]  head_mask;

  assign full      = (count_q == CntW'(DEPTH));
  assign req_ready = !full && !rst;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_size != 2'b11);
  assign illegal   = accept && (req_size == 2'b11);

  assign head_waddr = waddr_q[rptr_q];
  assign head_data  = data_q[rptr_q];
  assign head_mask  = mask_q[rptr_q];

  // An entry leaves the FIFO after its last beat: HI always, LO only when nothing spills over.
  assign pop = mem_ready && ((state_q == StHi) ||
                             ((state_q == StLo) && (head_mask[7:4] == 4'b0000)));

  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    base_mask = 4'b0001;
    size_data = {24'b0, req_data[7:0]};
    case (req_size)
      2'b01: begin
        base_mask = 4'b0011;
        size_data = {16'b0, req_data[15:0]};
      end
      2'b10: begin
        base_mask = 4'b1111;
        size_data = req_data;
      end
      default: ;
    endcase
    enq_mask = {4'b0000, base_mask} << req_addr[1:0];
    enq_data = {32'b0, size_data} << {req_addr[1:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wptr_q] <= req_addr[31:2];
      data_q[wptr_q]  <= enq_data;
      mask_q[wptr_q]  <= enq_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      err_q   <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (push) state_d = StLo;
      StLo: begin
        if (mem_ready) begin
          if (head_mask[7:4] != 4'b0000) state_d = StHi;
          else                           state_d = (count_d != '0) ? StLo : StIdle;
        end
      end
      StHi: if (mem_ready) state_d = (count_d != '0) ? StLo : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_wmask = '0;
    split     = 1'b0;
    unique case (state_q)
      StLo: begin
        mem_wen   = 1'b1;
        mem_addr  = {head_waddr, 2'b00};
        mem_din   = head_data[31:0];
        mem_wmask = head_mask[3:0];
      end
      StHi: begin
        mem_wen   = 1'b1;
        mem_addr  = {head_waddr + 30'd1, 2'b00};
        mem_din   = head_data[63:32];
        mem_wmask = head_mask[7:4];
        split     = mem_ready;
      end
      default: ;
    endcase
  end

  assign busy     = (count_q != '0);
  assign err_size = err_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Self-checking bench for store_sequencer: directed scenarios plus randomized traffic
// checked against a byte-level reference model.
module tb_store_sequencer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wen;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wmask;
  logic        busy;
  logic        split;
  logic        err_size;

  int errors = 0;
  int checks = 0;

  // Expected beat stream: one element per write beat.
  logic [31:0] q_addr[$];
  logic [31:0] q_din[$];
  logic [3:0]  q_mask[$];
  bit          q_split[$];
  bit          q_last[$];

  always #5 clk = ~clk;

  store_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_wen   (mem_wen),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wmask (mem_wmask),
    .busy      (busy),
    .split     (split),
    .err_size  (err_size)
  );

  task automatic put_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
  endtask

  // Walk the stored bytes one address at a time and group them by word.
  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int          n;
    logic [31:0] ba, w, cur_w, din;
    logic [3:0]  m;
    logic [7:0]  byte_v;
    bit          second;
    n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    cur_w  = {a[31:2], 2'b00};
    din    = '0;
    m      = '0;
    second = 1'b0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      w  = {ba[31:2], 2'b00};
      if (w != cur_w) begin
        q_addr.push_back(cur_w); q_din.push_back(din); q_mask.push_back(m);
        q_split.push_back(1'b0); q_last.push_back(1'b0);
        cur_w  = w;
        din    = '0;
        m      = '0;
        second = 1'b1;
      end
      byte_v = d[8*i +: 8];
      din    = din | (32'(byte_v) << (8 * int'(ba[1:0])));
      m      = m | (4'b0001 << ba[1:0]);
    end
    q_addr.push_back(cur_w); q_din.push_back(din); q_mask.push_back(m);
    q_split.push_back(second); q_last.push_back(1'b1);
  endtask

  function automatic int model_entries();
    int e = 0;
    foreach (q_last[i]) if (q_last[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    put_req(1'b0, '0, '0, 2'b00);
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b want 0", req_ready);
    end
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask, busy, split, err_size} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wen=%b addr=%h din=%h mask=%b busy=%b split=%b err=%b want all 0",
               mem_wen, mem_addr, mem_din, mem_wmask, busy, split, err_size);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_release: got %b want 1", req_ready);
    end
  endtask

  task automatic test_byte();
    mem_ready = 1'b1;
    put_req(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00);
    @(negedge clk);
    put_req(1'b0, '0, '0, 2'b00);
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask, busy} !== {1'b1, 32'h1000, 32'hAB00_0000, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL byte_beat: got wen=%b addr=%h din=%h mask=%b busy=%b want 1 00001000 ab000000 1000 1",
               mem_wen, mem_addr, mem_din, mem_wmask, busy);
    end
    @(negedge clk);
    checks++;
    if ({mem_wen, busy} !== 2'b00) begin
      errors++; $display("FAIL byte_done: got wen=%b busy=%b want 0 0", mem_wen, busy);
    end
  endtask

  task automatic test_split_word();
    mem_ready = 1'b1;
    put_req(1'b1, 32'h0000_1002, 32'h1122_3344, 2'b10);
    @(negedge clk);
    put_req(1'b0, '0, '0, 2'b00);
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask, split} !== {1'b1, 32'h1000, 32'h3344_0000, 4'b1100, 1'b0}) begin
      errors++;
      $display("FAIL sw_beat1: got wen=%b addr=%h din=%h mask=%b split=%b want 1 00001000 33440000 1100 0",
               mem_wen, mem_addr, mem_din, mem_wmask, split);
    end
    @(negedge clk);
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask, split} !== {1'b1, 32'h1004, 32'h0000_1122, 4'b0011, 1'b1}) begin
      errors++;
      $display("FAIL sw_beat2: got wen=%b addr=%h din=%h mask=%b split=%b want 1 00001004 00001122 0011 1",
               mem_wen, mem_addr, mem_din, mem_wmask, split);
    end
    @(negedge clk);
    checks++;
    if ({mem_wen, busy, split} !== 3'b000) begin
      errors++; $display("FAIL sw_done: got wen=%b busy=%b split=%b want 0 0 0", mem_wen, busy, split);
    end
  endtask

  task automatic test_wrap();
    mem_ready = 1'b1;
    put_req(1'b1, 32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
    @(negedge clk);
    put_req(1'b0, '0, '0, 2'b00);
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask} !== {1'b1, 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000}) begin
      errors++;
      $display("FAIL wrap_beat1: got wen=%b addr=%h din=%h mask=%b want 1 fffffffc ef000000 1000",
               mem_wen, mem_addr, mem_din, mem_wmask);
    end
    @(negedge clk);
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask, split} !== {1'b1, 32'h0, 32'h0000_00BE, 4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL wrap_beat2: got wen=%b addr=%h din=%h mask=%b split=%b want 1 00000000 000000be 0001 1",
               mem_wen, mem_addr, mem_din, mem_wmask, split);
    end
    @(negedge clk);
  endtask

  task automatic test_full();
    mem_ready = 1'b0;
    put_req(1'b1, 32'h0000_2000, 32'hA0A0_A0A0, 2'b10);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_one: got %b want 1", req_ready);
    end
    put_req(1'b1, 32'h0000_2004, 32'hB1B2_B3B4, 2'b10);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_low: got %b want 0", req_ready);
    end
    put_req(1'b1, 32'h0000_2008, 32'hC1C2_C3C4, 2'b10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_wen, mem_addr, mem_din, mem_wmask, req_ready} !== {1'b1, 32'h2000, 32'hA0A0_A0A0, 4'b1111, 1'b0}) begin
        errors++;
        $display("FAIL full_frozen: got wen=%b addr=%h din=%h mask=%b ready=%b want 1 00002000 a0a0a0a0 1111 0",
                 mem_wen, mem_addr, mem_din, mem_wmask, req_ready);
      end
      if (i < 2) @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wen, mem_addr, mem_din, req_ready} !== {1'b1, 32'h2004, 32'hB1B2_B3B4, 1'b1}) begin
      errors++;
      $display("FAIL full_second: got wen=%b addr=%h din=%h ready=%b want 1 00002004 b1b2b3b4 1",
               mem_wen, mem_addr, mem_din, req_ready);
    end
    @(negedge clk);
    put_req(1'b0, '0, '0, 2'b00);
    checks++;
    if ({mem_wen, mem_addr, mem_din} !== {1'b1, 32'h2008, 32'hC1C2_C3C4}) begin
      errors++;
      $display("FAIL full_third: got wen=%b addr=%h din=%h want 1 00002008 c1c2c3c4",
               mem_wen, mem_addr, mem_din);
    end
    @(negedge clk);
    checks++;
    if ({mem_wen, busy} !== 2'b00) begin
      errors++; $display("FAIL full_drained: got wen=%b busy=%b want 0 0", mem_wen, busy);
    end
  endtask

  task automatic test_illegal();
    mem_ready = 1'b0;
    put_req(1'b1, 32'h0000_3000, 32'h0000_005A, 2'b00);
    @(negedge clk);
    put_req(1'b1, 32'h0000_3010, 32'hFFFF_FFFF, 2'b11);
    @(negedge clk);
    put_req(1'b0, '0, '0, 2'b00);
    checks++;
    if ({err_size, busy, mem_addr, mem_wmask} !== {1'b1, 1'b1, 32'h3000, 4'b0001}) begin
      errors++;
      $display("FAIL illegal_pulse: got err=%b busy=%b addr=%h mask=%b want 1 1 00003000 0001",
               err_size, busy, mem_addr, mem_wmask);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({err_size, busy, mem_wen} !== 3'b000) begin
      errors++;
      $display("FAIL illegal_not_queued: got err=%b busy=%b wen=%b want 0 0 0", err_size, busy, mem_wen);
    end
  endtask

  task automatic test_reset_mid_split();
    mem_ready = 1'b0;
    put_req(1'b1, 32'h0000_4001, 32'hDEAD_BEEF, 2'b10);
    @(negedge clk);
    put_req(1'b0, '0, '0, 2'b00);
    checks++;
    if ({mem_wen, mem_addr, mem_wmask} !== {1'b1, 32'h4000, 4'b1110}) begin
      errors++;
      $display("FAIL rstsplit_lo: got wen=%b addr=%h mask=%b want 1 00004000 1110", mem_wen, mem_addr, mem_wmask);
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wen, mem_addr, mem_din, mem_wmask, busy, split, err_size, req_ready} !== '0) begin
      errors++;
      $display("FAIL rstsplit_cleared: got wen=%b addr=%h din=%h mask=%b busy=%b split=%b err=%b ready=%b want all 0",
               mem_wen, mem_addr, mem_din, mem_wmask, busy, split, err_size, req_ready);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_wen, busy, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rstsplit_no_hi: got wen=%b busy=%b ready=%b want 0 0 1", mem_wen, busy, req_ready);
    end
  endtask

  task automatic test_random();
    bit          exp_err = 1'b0;
    bit          exp_ready, exp_split, quiet;
    logic [31:0] a, d;
    logic [1:0]  sz;
    for (int cyc = 0; cyc < 600; cyc++) begin
      quiet     = (cyc >= 580);
      exp_ready = (model_entries() < DEPTH);
      checks++;
      if ({req_ready, busy, err_size} !== {exp_ready, model_entries() != 0, exp_err}) begin
        errors++;
        $display("FAIL rand_status cyc=%0d: got ready=%b busy=%b err=%b want %b %b %b", cyc,
                 req_ready, busy, err_size, exp_ready, model_entries() != 0, exp_err);
      end
      checks++;
      if (q_addr.size() == 0) begin
        if ({mem_wen, mem_addr, mem_din, mem_wmask} !== '0) begin
          errors++;
          $display("FAIL rand_idle cyc=%0d: got wen=%b addr=%h din=%h mask=%b want all 0", cyc,
                   mem_wen, mem_addr, mem_din, mem_wmask);
        end
      end else if ({mem_wen, mem_addr, mem_din, mem_wmask} !== {1'b1, q_addr[0], q_din[0], q_mask[0]}) begin
        errors++;
        $display("FAIL rand_beat cyc=%0d: got wen=%b addr=%h din=%h mask=%b want 1 %h %h %b", cyc,
                 mem_wen, mem_addr, mem_din, mem_wmask, q_addr[0], q_din[0], q_mask[0]);
      end
      mem_ready = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      exp_split = (q_addr.size() != 0) && q_split[0] && mem_ready;
      checks++;
      if (split !== exp_split) begin
        errors++; $display("FAIL rand_split cyc=%0d: got %b want %b", cyc, split, exp_split);
      end
      if ((q_addr.size() != 0) && mem_ready) begin
        void'(q_addr.pop_front()); void'(q_din.pop_front()); void'(q_mask.pop_front());
        void'(q_split.pop_front()); void'(q_last.pop_front());
      end
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      put_req(!quiet && ($urandom_range(0, 1) == 1), a, d, sz);
      exp_err = 1'b0;
      if (req_valid && exp_ready) begin
        if (sz == 2'b11) exp_err = 1'b1;
        else             model_push(a, d, sz);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, mem_wen} !== 2'b00 || q_addr.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got busy=%b wen=%b model_beats=%0d want 0 0 0", busy, mem_wen, q_addr.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    put_req(1'b0, '0, '0, 2'b00);
    test_reset();
    test_byte();
    test_split_word();
    test_wrap();
    test_full();
    test_illegal();
    test_reset_mid_split();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
